// File: rtl/store_narrow_unit.sv
// Store-side write path: narrows a register operand to byte/half/word and merges it into word memory.
// STORE_BYTE_ENABLE_EN adds o_mem_be and replaces the read-modify-write sequence with direct lane writes.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a request; decode and capture on i_valid
// RD    | issue memory read of the target word
// CAP   | register read data into the merge buffer
// WR    | issue merged write, pulse o_done
// ERR   | pulse o_misaligned for a rejected request
module store_narrow_unit #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [BITS_ADDR-1:0] i_addr,
  input  logic [BITS_DATA-1:0] i_data,
  input  logic [1:0]           i_size,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_misaligned,
  output logic [BITS_ADDR-3:0] o_mem_addr,
  output logic                 o_mem_rd_en,
  input  logic [BITS_DATA-1:0] i_mem_rdata,
  output logic                 o_mem_wr_en,
  output logic [BITS_DATA-1:0] o_mem_wdata
`ifdef STORE_BYTE_ENABLE_EN
  ,
  output logic [3:0]           o_mem_be
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t               state_q, state_nxt;
  logic [BITS_ADDR-1:0] addr_q;
  logic [BITS_DATA-1:0] data_q;
  logic [1:0]           size_q;
  logic                 accept;
  logic                 bad_req;
  logic [3:0]           lane_be;
  logic [BITS_DATA-1:0] lane_mask;
  logic [BITS_DATA-1:0] placed;

  assign o_ready = (state_q == S_IDLE) && !i_reset;
  assign accept  = o_ready && i_valid;

  assign bad_req = (i_size == 2'b11) ||
                   ((i_size == SZ_HALF) && i_addr[0]) ||
                   ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (bad_req)
            state_nxt = S_ERR;
          else if (i_size == SZ_WORD)
            state_nxt = S_WR;
          else
`ifdef STORE_BYTE_ENABLE_EN
            state_nxt = S_WR;
`else
            state_nxt = S_RD;
`endif
        end
      end
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = S_WR;
      S_WR:    state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        addr_q <= i_addr;
        data_q <= i_data;
        size_q <= i_size;
      end
    end
  end

  // Replicate the operand across lanes; the lane mask then picks the target slot.
  always_comb begin
    lane_be = 4'b1111;
    placed  = data_q;
    case (size_q)
      SZ_BYTE: begin
        lane_be = 4'b0001 << addr_q[1:0];
        placed  = {4{data_q[7:0]}};
      end
      SZ_HALF: begin
        lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
        placed  = {2{data_q[15:0]}};
      end
      default: begin
        lane_be = 4'b1111;
        placed  = data_q;
      end
    endcase
  end

  assign lane_mask = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};

  assign o_mem_addr   = addr_q[BITS_ADDR-1:2];
  assign o_mem_rd_en  = (state_q == S_RD);
  assign o_mem_wr_en  = (state_q == S_WR);
  assign o_done       = (state_q == S_WR);
  assign o_misaligned = (state_q == S_ERR);

`ifdef STORE_BYTE_ENABLE_EN
  assign o_mem_wdata = (state_q == S_WR) ? (placed & lane_mask) : '0;
  assign o_mem_be    = (state_q == S_WR) ? lane_be : 4'b0000;
`else
  logic [BITS_DATA-1:0] buf_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      buf_q <= '0;
    else if (state_q == S_CAP)
      buf_q <= i_mem_rdata;
  end

  assign o_mem_wdata = (state_q == S_WR) ? ((buf_q & ~lane_mask) | (placed & lane_mask)) : '0;
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit with a small synchronous word memory behind it.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [9:0]  i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_size;
  logic        o_ready, o_done, o_misaligned;
  logic [7:0]  o_mem_addr;
  logic        o_mem_rd_en, o_mem_wr_en;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_mem_wdata;
`ifdef STORE_BYTE_ENABLE_EN
  logic [3:0]  o_mem_be;
`endif

  int errors = 0;
  int checks = 0;
  int rd_count = 0;
  int wr_count = 0;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  store_narrow_unit #(.BITS_DATA(32), .BITS_ADDR(10)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_valid      (i_valid),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_size       (i_size),
    .o_ready      (o_ready),
    .o_done       (o_done),
    .o_misaligned (o_misaligned),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rd_en  (o_mem_rd_en),
    .i_mem_rdata  (i_mem_rdata),
    .o_mem_wr_en  (o_mem_wr_en),
    .o_mem_wdata  (o_mem_wdata)
`ifdef STORE_BYTE_ENABLE_EN
    ,
    .o_mem_be     (o_mem_be)
`endif
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (o_mem_rd_en) begin
      i_mem_rdata <= mem[o_mem_addr];
      rd_count    <= rd_count + 1;
    end
    if (o_mem_wr_en) begin
      wr_count <= wr_count + 1;
`ifdef STORE_BYTE_ENABLE_EN
      for (int k = 0; k < 4; k++)
        if (o_mem_be[k]) mem[o_mem_addr][8*k +: 8] <= o_mem_wdata[8*k +: 8];
`else
      mem[o_mem_addr] <= o_mem_wdata;
`endif
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present one request for a single edge; returns at the negedge of cycle T+1.
  task automatic issue(input logic [9:0] a, input logic [1:0] s, input logic [31:0] d);
    i_valid = 1'b1; i_addr = a; i_size = s; i_data = d;
    @(negedge clk);
    i_valid = 1'b0; i_addr = '0; i_size = '0; i_data = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_valid = 1'b1; i_addr = 10'h010; i_size = 2'b10; i_data = 32'h12345678;
    @(negedge clk); @(negedge clk);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", o_mem_wr_en); end
    checks++; if (o_mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", o_mem_rd_en); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", o_misaligned); end
    checks++; if (o_mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", o_mem_addr); end
    checks++; if (o_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", o_mem_wdata); end
    rst = 1'b0;
    i_valid = 1'b0; i_addr = '0; i_size = '0; i_data = '0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_word_store;
    int rd0;
    preload(8'h04, 32'h0);
    rd0 = rd_count;
    issue(10'h010, 2'b10, 32'hDEADBEEF);
    checks++; if (o_mem_wr_en !== 1'b1) begin errors++; $display("FAIL sw_wr_en got=%b exp=1", o_mem_wr_en); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL sw_done got=%b exp=1", o_done); end
    checks++; if (o_mem_addr !== 8'h04) begin errors++; $display("FAIL sw_addr got=%h exp=04", o_mem_addr); end
    checks++; if (o_mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_mem_wdata); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL sw_busy_ready got=%b exp=0", o_ready); end
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_back got=%b exp=1", o_ready); end
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL sw_wr_drop got=%b exp=0", o_mem_wr_en); end
    checks++; if (mem[8'h04] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[8'h04]); end
    checks++; if (rd_count !== rd0) begin errors++; $display("FAIL sw_no_read got=%0d exp=%0d", rd_count, rd0); end
  endtask

`ifndef STORE_BYTE_ENABLE_EN
  task automatic test_byte_rmw;
    preload(8'h04, 32'h11223344);
    issue(10'h012, 2'b00, 32'hFFFFFFAB);
    checks++; if (o_mem_rd_en !== 1'b1) begin errors++; $display("FAIL sb_rd_t1 got=%b exp=1", o_mem_rd_en); end
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL sb_wr_t1 got=%b exp=0", o_mem_wr_en); end
    checks++; if (o_mem_addr !== 8'h04) begin errors++; $display("FAIL sb_addr_t1 got=%h exp=04", o_mem_addr); end
    @(negedge clk);
    checks++; if ({o_mem_rd_en, o_mem_wr_en, o_ready} !== 3'b000) begin errors++; $display("FAIL sb_cap_strobes got=%b exp=000", {o_mem_rd_en, o_mem_wr_en, o_ready}); end
    checks++; if (o_mem_addr !== 8'h04) begin errors++; $display("FAIL sb_addr_t2 got=%h exp=04", o_mem_addr); end
    @(negedge clk);
    checks++; if ({o_mem_wr_en, o_done, o_mem_rd_en} !== 3'b110) begin errors++; $display("FAIL sb_wr_t3 got=%b exp=110", {o_mem_wr_en, o_done, o_mem_rd_en}); end
    checks++; if (o_mem_wdata !== 32'h11AB3344) begin errors++; $display("FAIL sb_wdata got=%h exp=11ab3344", o_mem_wdata); end
    checks++; if (o_mem_addr !== 8'h04) begin errors++; $display("FAIL sb_addr_t3 got=%h exp=04", o_mem_addr); end
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL sb_ready_back got=%b exp=1", o_ready); end
    checks++; if (mem[8'h04] !== 32'h11AB3344) begin errors++; $display("FAIL sb_mem got=%h exp=11ab3344", mem[8'h04]); end
  endtask

  task automatic test_reset_mid_rmw;
    int wr0;
    preload(8'h04, 32'h11223344);
    wr0 = wr_count;
    issue(10'h012, 2'b00, 32'h000000AB);
    @(negedge clk);
    checks++; if ({o_mem_rd_en, o_mem_wr_en} !== 2'b00) begin errors++; $display("FAIL rst_mid_cap got=%b exp=00", {o_mem_rd_en, o_mem_wr_en}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr got=%b exp=0", o_mem_wr_en); end
    checks++; if (o_mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_addr_clr got=%h exp=00", o_mem_addr); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", o_ready); end
    @(negedge clk); @(negedge clk);
    checks++; if (wr_count !== wr0) begin errors++; $display("FAIL rst_mid_no_write got=%0d exp=%0d", wr_count, wr0); end
    checks++; if (mem[8'h04] !== 32'h11223344) begin errors++; $display("FAIL rst_mid_mem got=%h exp=11223344", mem[8'h04]); end
  endtask
`endif

  typedef struct packed {
    logic [9:0]  a;
    logic [1:0]  s;
    logic [31:0] d;
    logic [31:0] init;
    logic [31:0] mem_exp;
    logic [31:0] be_wdata;
    logic [3:0]  be;
  } lane_vec_t;

  task automatic test_lane_placement;
    lane_vec_t tbl [6];
    int lat;
    int exp_lat;
`ifdef STORE_BYTE_ENABLE_EN
    exp_lat = 1;
`else
    exp_lat = 3;
`endif
    tbl[0] = '{10'h012, 2'b01, 32'h0000CAFE, 32'h11223344, 32'hCAFE3344, 32'hCAFE0000, 4'b1100};
    tbl[1] = '{10'h010, 2'b01, 32'h1234BEEF, 32'h11223344, 32'h1122BEEF, 32'h0000BEEF, 4'b0011};
    tbl[2] = '{10'h013, 2'b00, 32'h0000005A, 32'h11223344, 32'h5A223344, 32'h5A000000, 4'b1000};
    tbl[3] = '{10'h010, 2'b00, 32'hFFFFFFC3, 32'h11223344, 32'h112233C3, 32'h000000C3, 4'b0001};
    tbl[4] = '{10'h011, 2'b00, 32'h00000077, 32'h11223344, 32'h11227744, 32'h00007700, 4'b0010};
    tbl[5] = '{10'h014, 2'b10, 32'hA5A55A5A, 32'h11223344, 32'hA5A55A5A, 32'hA5A55A5A, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      preload(tbl[i].a[9:2], tbl[i].init);
      issue(tbl[i].a, tbl[i].s, tbl[i].d);
      lat = 1;
      while (o_mem_wr_en !== 1'b1 && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      checks++; if (o_mem_wr_en !== 1'b1) begin errors++; $display("FAIL lane%0d_timeout wr_en=%b after %0d cycles", i, o_mem_wr_en, lat); end
      checks++; if (lat != ((tbl[i].s == 2'b10) ? 1 : exp_lat)) begin errors++; $display("FAIL lane%0d_latency got=%0d exp=%0d", i, lat, (tbl[i].s == 2'b10) ? 1 : exp_lat); end
`ifdef STORE_BYTE_ENABLE_EN
      checks++; if (o_mem_wdata !== tbl[i].be_wdata) begin errors++; $display("FAIL lane%0d_wdata got=%h exp=%h", i, o_mem_wdata, tbl[i].be_wdata); end
      checks++; if (o_mem_be !== tbl[i].be) begin errors++; $display("FAIL lane%0d_be got=%b exp=%b", i, o_mem_be, tbl[i].be); end
`else
      checks++; if (o_mem_wdata !== tbl[i].mem_exp) begin errors++; $display("FAIL lane%0d_wdata got=%h exp=%h", i, o_mem_wdata, tbl[i].mem_exp); end
`endif
      @(negedge clk);
      checks++; if (mem[tbl[i].a[9:2]] !== tbl[i].mem_exp) begin errors++; $display("FAIL lane%0d_mem got=%h exp=%h", i, mem[tbl[i].a[9:2]], tbl[i].mem_exp); end
    end
  endtask

  task automatic test_misaligned;
    logic [9:0] addrs [3];
    logic [1:0] sizes [3];
    int rd0, wr0;
    addrs[0] = 10'h013; sizes[0] = 2'b01;
    addrs[1] = 10'h012; sizes[1] = 2'b10;
    addrs[2] = 10'h010; sizes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rd0 = rd_count;
      wr0 = wr_count;
      issue(addrs[i], sizes[i], 32'h55AA55AA);
      checks++; if (o_misaligned !== 1'b1) begin errors++; $display("FAIL mis%0d_pulse got=%b exp=1", i, o_misaligned); end
      checks++; if ({o_mem_rd_en, o_mem_wr_en, o_done, o_ready} !== 4'b0000) begin errors++; $display("FAIL mis%0d_strobes got=%b exp=0000", i, {o_mem_rd_en, o_mem_wr_en, o_done, o_ready}); end
      @(negedge clk);
      checks++; if ({o_ready, o_misaligned} !== 2'b10) begin errors++; $display("FAIL mis%0d_recover got=%b exp=10", i, {o_ready, o_misaligned}); end
      checks++; if ((rd_count != rd0) || (wr_count != wr0)) begin errors++; $display("FAIL mis%0d_no_access rd=%0d/%0d wr=%0d/%0d", i, rd_count, rd0, wr_count, wr0); end
    end
  endtask

  // Second request is held valid while the first is still in WR; it must be taken exactly once.
  task automatic test_back_to_back;
    int wr0;
    logic [1:0]  size_b;
    logic [31:0] data_b, wdata_b, mem_b;
`ifdef STORE_BYTE_ENABLE_EN
    size_b = 2'b00; data_b = 32'h00000044; wdata_b = 32'h00004400; mem_b = 32'h99884477;
`else
    size_b = 2'b10; data_b = 32'h22222222; wdata_b = 32'h22222222; mem_b = 32'h22222222;
`endif
    preload(8'h09, 32'h99887777);
    wr0 = wr_count;
    i_valid = 1'b1; i_addr = 10'h020; i_size = 2'b10; i_data = 32'h11111111;
    @(negedge clk);
    checks++; if ({o_mem_wr_en, o_mem_wdata} !== {1'b1, 32'h11111111}) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/11111111", o_mem_wr_en, o_mem_wdata); end
    i_addr = (size_b == 2'b10) ? 10'h024 : 10'h025; i_size = size_b; i_data = data_b;
    @(negedge clk);
    checks++; if ({o_ready, o_mem_wr_en} !== 2'b10) begin errors++; $display("FAIL b2b_gap got=%b exp=10", {o_ready, o_mem_wr_en}); end
    @(negedge clk);
    i_valid = 1'b0;
    checks++; if ({o_mem_wr_en, o_mem_addr} !== {1'b1, 8'h09}) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/09", o_mem_wr_en, o_mem_addr); end
    checks++; if (o_mem_wdata !== wdata_b) begin errors++; $display("FAIL b2b_second_wdata got=%h exp=%h", o_mem_wdata, wdata_b); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (wr_count - wr0 != 2) begin errors++; $display("FAIL b2b_write_count got=%0d exp=2", wr_count - wr0); end
    checks++; if (mem[8'h08] !== 32'h11111111) begin errors++; $display("FAIL b2b_mem_a got=%h exp=11111111", mem[8'h08]); end
    checks++; if (mem[8'h09] !== mem_b) begin errors++; $display("FAIL b2b_mem_b got=%h exp=%h", mem[8'h09], mem_b); end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_addr = '0; i_size = '0; i_data = '0;
    test_reset();
    test_word_store();
`ifndef STORE_BYTE_ENABLE_EN
    test_byte_rmw();
`endif
    test_lane_placement();
    test_misaligned();
`ifndef STORE_BYTE_ENABLE_EN
    test_reset_mid_rmw();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side write path for the MIPS data memory. It truncates a 32-bit register operand to byte, halfword or word, places it in the correct byte lane, and merges it into a word-addressed synchronous data memory. Without byte-enable support the merge is a read-modify-write sequence. It sits in the MEM stage, between the EX/MEM pipeline register and the data-memory BRAM. It is the inverse of the load/immediate extension path: it narrows 32-bit values instead of widening them.

## Interface
Parameters:
- BITS_DATA, 32, register/memory word width; fixed at 32, four 8-bit lanes.
- BITS_ADDR, 10, byte-address width; memory word address is BITS_ADDR-2 bits.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  store request present.
- i_addr  in  BITS_ADDR  byte address of the store.
- i_data  in  BITS_DATA  register operand; only low 8/16/32 bits are used.
- i_size  in  2  store size: 00 byte (SB), 01 half (SH), 10 word (SW), 11 illegal.
- o_ready  out  1  block idle; request accepted when i_valid & o_ready.
- o_done  out  1  one-cycle pulse in the cycle the memory write is issued.
- o_misaligned  out  1  one-cycle pulse for a rejected request; no memory access.
- o_mem_addr  out  BITS_ADDR-2  word address (captured i_addr[BITS_ADDR-1:2]).
- o_mem_rd_en  out  1  memory read strobe.
- i_mem_rdata  in  BITS_DATA  memory read data, valid the cycle after o_mem_rd_en.
- o_mem_wr_en  out  1  memory write strobe.
- o_mem_wdata  out  BITS_DATA  merged write word.
- o_mem_be  out  4  byte enables. Present only with STORE_BYTE_ENABLE_EN.

## Operation
- **Acceptance**
  - In IDLE, o_ready=1. On i_valid=1, capture addr, data and size, then decode.
  - i_valid is ignored while o_ready=0. The requester holds the request until it is accepted.
- **Alignment check**
  - A half with addr[0]=1 is misaligned.
  - A word with addr[1:0]≠00 is misaligned.
  - i_size=11 is illegal.
  - All three cases go to ERR: o_misaligned=1 for one cycle, no strobes, then IDLE.
- **Lane placement (little-endian)**
  - Byte at addr[1:0]=k: data[7:0] goes to bits [8k+7:8k].
  - Half at addr[1]=h: data[15:0] goes to bits [16h+15:16h].
  - Word: data[31:0] written unmodified.
- **FSM states:** IDLE, RD, CAP, WR, ERR.
  - IDLE → WR for a word store.
  - IDLE → RD for a byte or half store.
  - IDLE → ERR for a misaligned or illegal request.
  - RD: o_mem_rd_en=1, o_mem_addr valid. Always → CAP.
  - CAP: register i_mem_rdata into the merge buffer. Always → WR.
  - WR: o_mem_wr_en=1, o_mem_wdata = merge buffer with the target lanes replaced by placed data; o_done=1. Always → IDLE.
  - ERR: o_misaligned=1. Always → IDLE.
- **Strobe rules**
  - o_mem_addr is held stable from RD through WR.
  - Only one of rd_en or wr_en is asserted in any cycle.
  - Bytes outside the target lanes are written back exactly as read.
- **Reset**
  - i_reset=1 in any state forces IDLE next edge and clears all capture registers.
  - An interrupted RMW issues no write.

## Timing
- **Reset values:** o_ready=1 (0 while i_reset is high); all other outputs 0.
- **Latency**, with acceptance at edge T:
  - Word store: WR/o_done in cycle T+1.
  - Byte/half store: RD at T+1, CAP at T+2, WR/o_done at T+3.
  - Misaligned or illegal: o_misaligned at T+1.
- **Back-to-back:** o_ready returns to 1 in the cycle after WR or ERR. Maximum throughput is one word store per 2 cycles and one byte/half store per 4 cycles.
- **Memory assumption:** i_mem_rdata is sampled only in CAP, one cycle after RD.

## Configuration
- **STORE_BYTE_ENABLE_EN defined**
  - The o_mem_be port exists and the RD and CAP states are never entered.
  - Every aligned store goes IDLE → WR with latency T+1.
  - o_mem_be: byte k → 1<<k; half h → 4'b0011<<(2h); word → 4'b1111.
  - Non-target lanes of o_mem_wdata carry 0.
- **Not defined**
  - No o_mem_be port.
  - Byte and half stores use the RMW sequence above.

## Test plan
- **Word store:** SW addr=0x010, data=0xDEADBEEF → T+1: wr_en=1, mem_addr=0x004, wdata=0xDEADBEEF, done=1; rd_en never asserted.
- **Byte RMW:** memory word 0x004 = 0x11223344; SB addr=0x012, data=0xFFFFFFAB → rd at T+1, wr at T+3 with wdata=0x11AB3344.
- **Half RMW:** same memory word; SH addr=0x012, data=0x0000CAFE → wdata=0xCAFE3344.
- **Misaligned:** SH addr=0x013 and SW addr=0x012 each → o_misaligned pulse at T+1, no rd_en or wr_en, o_ready=1 at T+2. Illegal size: i_size=11 → same response.
- **Reset mid-RMW:** assert i_reset during CAP → next cycle IDLE, o_ready=1, no wr_en ever issued, memory word unchanged.
- **Byte enables (STORE_BYTE_ENABLE_EN):** SB addr=0x011 → T+1: wr_en=1, o_mem_be=4'b0010, no rd_en; back-to-back requests accepted every 2 cycles.
